// File: rtl/demux1x2_fifo_pkg.sv
// Shared constants for the demux1x2_fifo steering block and its channel FIFOs.
package demux1x2_fifo_pkg;

    localparam logic [1:0] ES_A     = 2'b00;
    localparam logic [1:0] ES_B     = 2'b01;
    localparam logic [1:0] ES_DROP0 = 2'b10;
    localparam logic [1:0] ES_DROP1 = 2'b11;

    localparam int unsigned W_DEFAULT     = 4;
    localparam int unsigned DEPTH_DEFAULT = 4;
    localparam int unsigned CW_DEFAULT    = 8;

    typedef enum logic [1:0] {
        RouteA,
        RouteB,
        RouteDrop
    } route_e;

    function automatic route_e decode_route(input logic [1:0] es);
        route_e r;
        unique case (es)
            ES_A:     r = RouteA;
            ES_B:     r = RouteB;
            default:  r = RouteDrop;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: dout always shows the head entry, valid when !empty.
module sync_fifo_fwft #(
    parameter int unsigned W     = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic         Clock,
    input  logic         Reset_b,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNTW = $clog2(DEPTH + 1);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

    logic [W-1:0]    mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    // Guard both sides internally so a misbehaving caller cannot corrupt the state.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign dout = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared on reset so the head output reads zero afterwards.
    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/demux1x2_fifo.sv
// Steers a word stream into channel FIFO A or B by ES code, dropping and counting 1x codes.
module demux1x2_fifo
    import demux1x2_fifo_pkg::*;
#(
    parameter int unsigned W     = W_DEFAULT,
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned CW    = CW_DEFAULT
) (
    input  logic          Clock,
    input  logic          Reset_b,
    input  logic [W-1:0]  D,
    input  logic [1:0]    ES,
    input  logic          D_valid,
    output logic          D_ready,
    output logic [W-1:0]  A,
    output logic          A_valid,
    input  logic          A_ready,
    output logic [W-1:0]  B,
    output logic          B_valid,
    input  logic          B_ready,
    output logic [CW-1:0] DROP_CNT
);

    route_e        route;
    logic          accept;
    logic          push_a, push_b, drop;
    logic          empty_a, empty_b, full_a, full_b;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    assign route = decode_route(ES);

    // Ready depends only on ES and the addressed FIFO, never on D_valid.
    always_comb begin
        D_ready = 1'b1;
        unique case (route)
            RouteA:  D_ready = !full_a;
            RouteB:  D_ready = !full_b;
            default: D_ready = 1'b1;
        endcase
    end

    assign accept = D_valid && D_ready;
    assign push_a = accept && (route == RouteA);
    assign push_b = accept && (route == RouteB);
    assign drop   = accept && (route == RouteDrop);

    assign A_valid = !empty_a;
    assign B_valid = !empty_b;

    sync_fifo_fwft #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .Clock   (Clock),
        .Reset_b (Reset_b),
        .push    (push_a),
        .din     (D),
        .pop     (A_ready),
        .dout    (A),
        .empty   (empty_a),
        .full    (full_a)
    );

    sync_fifo_fwft #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .Clock   (Clock),
        .Reset_b (Reset_b),
        .push    (push_b),
        .din     (D),
        .pop     (B_ready),
        .dout    (B),
        .empty   (empty_b),
        .full    (full_b)
    );

    // Wraps modulo 2^CW.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            drop_cnt_d = drop_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign DROP_CNT = drop_cnt_q;

endmodule
